// File: rtl/cordic_bus_bridge.sv
// APB register front end for the CORDIC Controller: operand/control shadows, start pulse,
// run tracking with timeout, result capture, completion counter and a maskable sticky interrupt.
module cordic_bus_bridge #(
  parameter int P_WIDTH     = 32,
  parameter int P_START_BIT = 0,
  parameter int P_READY_BIT = 0,
  parameter int P_TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [6:0]         paddr,
  input  logic [P_WIDTH-1:0] pwdata,
  output logic [P_WIDTH-1:0] prdata,
  output logic               pready,
  output logic               pslverr,
  output logic [P_WIDTH-1:0] xInput,
  output logic [P_WIDTH-1:0] yInput,
  output logic [P_WIDTH-1:0] zInput,
  output logic [P_WIDTH-1:0] controlRegisterInput,
  input  logic [P_WIDTH-1:0] xOutput,
  input  logic [P_WIDTH-1:0] yOutput,
  input  logic [P_WIDTH-1:0] zOutput,
  input  logic [P_WIDTH-1:0] controlRegisterOutput,
  input  logic               interrupt,
  output logic               irq
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LAUNCH  = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [P_WIDTH-1:0] START_MASK = P_WIDTH'(1) << P_START_BIT;
  localparam logic [15:0]        TMO_LOAD   = 16'(P_TIMEOUT);

  logic [1:0]         state_q, state_d;
  logic [P_WIDTH-1:0] x_op_q, x_op_d, y_op_q, y_op_d, z_op_q, z_op_d, ctrl_q, ctrl_d;
  logic [P_WIDTH-1:0] x_res_q, x_res_d, y_res_q, y_res_d, z_res_q, z_res_d;
  logic               done_q, done_d, tmo_q, tmo_d, irq_q, irq_d, seen_low_q, seen_low_d;
  logic [15:0]        count_q, count_d, tmr_q, tmr_d;
  logic [1:0]         irqen_q, irqen_d;

  logic       access, busy, addr_ok, op_reg, wr_ok, ready, done_set, tmo_set;
  logic [4:0] word;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^paddr[1:0];
  assign word    = paddr[6:2];
  assign access  = psel & penable;
  assign busy    = (state_q != S_IDLE);
  assign addr_ok = (word[4:3] == 2'b00);
  assign op_reg  = addr_ok & ~word[2];
  assign wr_ok   = access & pwrite & addr_ok & ~(busy & op_reg);
  assign ready   = controlRegisterOutput[P_READY_BIT];

  assign pready  = 1'b1;
  assign pslverr = access & (~addr_ok | (pwrite & busy & op_reg));
  assign xInput  = x_op_q;
  assign yInput  = y_op_q;
  assign zInput  = z_op_q;
  assign controlRegisterInput = (state_q == S_LAUNCH) ? (ctrl_q | START_MASK) : ctrl_q;
  assign irq     = irq_q;

  always_comb begin
    prdata = '0;
    if (access && addr_ok) begin
      case (word[2:0])
        3'd0: prdata = x_res_q;
        3'd1: prdata = y_res_q;
        3'd2: prdata = z_res_q;
        3'd3: prdata = ctrl_q;
        3'd4: prdata = controlRegisterOutput;
        3'd5: prdata = P_WIDTH'({busy, tmo_q, done_q});
        3'd6: prdata = P_WIDTH'(count_q);
        3'd7: prdata = P_WIDTH'(irqen_q);
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    x_op_d     = x_op_q;
    y_op_d     = y_op_q;
    z_op_d     = z_op_q;
    ctrl_d     = ctrl_q;
    x_res_d    = x_res_q;
    y_res_d    = y_res_q;
    z_res_d    = z_res_q;
    done_d     = done_q;
    tmo_d      = tmo_q;
    count_d    = count_q;
    irqen_d    = irqen_q;
    seen_low_d = seen_low_q;
    tmr_d      = tmr_q;
    done_set   = 1'b0;
    tmo_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_ok && word[2:0] == 3'd3 && pwdata[P_START_BIT]) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        seen_low_d = 1'b0;
        tmr_d      = TMO_LOAD;
        state_d    = S_RUN;
      end
      S_RUN: begin
        // Ready only counts once it has been observed low, so a stale ready cannot complete.
        tmr_d = tmr_q - 16'd1;
        if (!ready) seen_low_d = 1'b1;
        if (interrupt || (ready && seen_low_q)) begin
          state_d = S_CAPTURE;
        end else if (tmr_q == 16'd1) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        x_res_d  = xOutput;
        y_res_d  = yOutput;
        z_res_d  = zOutput;
        count_d  = count_q + 16'd1;
        done_set = 1'b1;
        state_d  = S_IDLE;
      end
    endcase

    if (wr_ok) begin
      case (word[2:0])
        3'd0: x_op_d = pwdata;
        3'd1: y_op_d = pwdata;
        3'd2: z_op_d = pwdata;
        3'd3: ctrl_d = pwdata & ~START_MASK;
        3'd5: begin
          if (pwdata[0]) done_d = 1'b0;
          if (pwdata[1]) tmo_d  = 1'b0;
        end
        3'd7: irqen_d = pwdata[1:0];
        default: ;
      endcase
    end

    // Hardware set overrides a same-cycle W1C.
    if (done_set) done_d = 1'b1;
    if (tmo_set)  tmo_d  = 1'b1;

    irq_d = |({tmo_q, done_q} & irqen_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      x_op_q     <= '0;
      y_op_q     <= '0;
      z_op_q     <= '0;
      ctrl_q     <= '0;
      x_res_q    <= '0;
      y_res_q    <= '0;
      z_res_q    <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      irq_q      <= 1'b0;
      count_q    <= '0;
      irqen_q    <= '0;
      seen_low_q <= 1'b0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_op_q     <= x_op_d;
      y_op_q     <= y_op_d;
      z_op_q     <= z_op_d;
      ctrl_q     <= ctrl_d;
      x_res_q    <= x_res_d;
      y_res_q    <= y_res_d;
      z_res_q    <= z_res_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      irq_q      <= irq_d;
      count_q    <= count_d;
      irqen_q    <= irqen_d;
      seen_low_q <= seen_low_d;
      tmr_q      <= tmr_d;
    end
  end

endmodule

// File: tb/tb_cordic_bus_bridge.sv
// Directed bench for cordic_bus_bridge: the controller side is driven by hand, expectations are constants.
module tb_cordic_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [6:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] xInput, yInput, zInput, controlRegisterInput;
  logic [31:0] xOutput = '0, yOutput = '0, zOutput = '0, controlRegisterOutput = '0;
  logic        interrupt = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cordic_bus_bridge #(
    .P_WIDTH(32), .P_START_BIT(0), .P_READY_BIT(0), .P_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .xInput(xInput), .yInput(yInput), .zInput(zInput),
    .controlRegisterInput(controlRegisterInput),
    .xOutput(xOutput), .yOutput(yOutput), .zOutput(zOutput),
    .controlRegisterOutput(controlRegisterOutput),
    .interrupt(interrupt), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Setup on one falling edge, access on the next; the access completes on the following rising edge.
  task automatic apb(input logic wr, input logic [6:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rdata = prdata;
    err   = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input string tag, input logic [6:0] addr, input logic [31:0] data,
                        input logic exp_err);
    logic [31:0] d;
    logic        e;
    apb(1'b1, addr, data, d, e);
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  task automatic apb_rd(input string tag, input logic [6:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb(1'b0, addr, 32'h0, d, e);
    check({tag, "_data"}, d, exp);
    check({tag, "_err"}, {31'b0, e}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        e;

    // Power-on reset values
    #2;
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_pready", {31'b0, pready}, 32'h1);
    check("rst_pslverr", {31'b0, pslverr}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_xin", xInput, 32'h0);
    check("rst_ctrlin", controlRegisterInput, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    apb_rd("rst_count", 7'h18, 32'h0);
    apb_rd("rst_irqreg", 7'h14, 32'h0);

    // Circular vectoring operands; controller ready is high and stale from a previous op
    controlRegisterOutput = 32'h1;
    xOutput = 32'h16A09E66;
    yOutput = 32'h00000003;
    zOutput = 32'hE0000000;
    apb_wr("wr_x", 7'h00, 32'hF3333333, 1'b0);
    apb_wr("wr_y", 7'h04, 32'h0CCCCCCD, 1'b0);
    apb_wr("wr_z", 7'h08, 32'h00000000, 1'b0);
    apb_wr("wr_irqen", 7'h1C, 32'h1, 1'b0);
    check("xin", xInput, 32'hF3333333);
    check("yin", yInput, 32'h0CCCCCCD);
    check("zin", zInput, 32'h0);

    apb_wr("start1", 7'h0C, 32'h31, 1'b0);
    check("launch_ctrlin", controlRegisterInput, 32'h31);
    @(posedge clk); #1;
    check("run_ctrlin", controlRegisterInput, 32'h30);

    // Busy protection while ready is still stale-high
    apb_wr("busy_x", 7'h00, 32'h12345678, 1'b1);
    check("busy_xin", xInput, 32'hF3333333);
    apb_rd("busy_irqreg", 7'h14, 32'h4);

    // Ready drops for one cycle then returns: completion, capture, irq two edges later
    controlRegisterOutput = 32'h0;
    @(posedge clk); #1;
    controlRegisterOutput = 32'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("irq_before", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_done", {31'b0, irq}, 32'h1);
    apb_rd("res_x", 7'h00, 32'h16A09E66);
    apb_rd("res_y", 7'h04, 32'h00000003);
    apb_rd("res_z", 7'h08, 32'hE0000000);
    apb_rd("done_irqreg", 7'h14, 32'h1);
    apb_rd("count1", 7'h18, 32'h1);
    apb_rd("ctrl_rd", 7'h0C, 32'h30);
    apb_wr("w1c_done", 7'h14, 32'h1, 1'b0);
    apb_rd("cleared_irqreg", 7'h14, 32'h0);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // Timeout: ready held low, no interrupt; RUN lasts exactly 8 cycles
    controlRegisterOutput = 32'h0;
    xOutput = 32'hAAAA5555;
    yOutput = 32'h5555AAAA;
    zOutput = 32'h0F0F0F0F;
    apb_wr("wr_irqen3", 7'h1C, 32'h3, 1'b0);
    apb_wr("start2", 7'h0C, 32'h31, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("tmo_irq_early", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("tmo_irq", {31'b0, irq}, 32'h1);
    apb_rd("tmo_irqreg", 7'h14, 32'h2);
    apb_rd("tmo_count", 7'h18, 32'h1);
    apb_rd("tmo_res_x", 7'h00, 32'h16A09E66);
    apb_wr("w1c_tmo", 7'h14, 32'h2, 1'b0);
    apb_rd("tmo_cleared", 7'h14, 32'h0);

    // W1C of DONE lands on the capture edge: the set wins
    interrupt = 1'b1;
    apb_wr("start3", 7'h0C, 32'h31, 1'b0);
    @(posedge clk);
    apb_wr("w1c_collide", 7'h14, 32'h1, 1'b0);
    apb_rd("collide_irqreg", 7'h14, 32'h1);
    apb_rd("count2", 7'h18, 32'h2);
    apb_rd("res_x2", 7'h00, 32'hAAAA5555);
    interrupt = 1'b0;

    // Address errors and live status
    apb(1'b0, 7'h24, 32'h0, d, e);
    check("bad_rd_err", {31'b0, e}, 32'h1);
    check("bad_rd_data", d, 32'h0);
    apb_wr("bad_wr", 7'h24, 32'hFFFFFFFF, 1'b1);
    controlRegisterOutput = 32'h000000A0;
    apb_rd("status", 7'h10, 32'h000000A0);
    apb_rd("irqen_rd", 7'h1C, 32'h3);

    // Control write without start only updates the shadow
    apb_wr("ctrl_nostart", 7'h0C, 32'h40, 1'b0);
    @(posedge clk); #1;
    check("nostart_ctrlin", controlRegisterInput, 32'h40);
    apb_rd("nostart_irqreg", 7'h14, 32'h1);

    // Back-to-back completions via interrupt
    interrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apb_wr("start_loop", 7'h0C, 32'h1, 1'b0);
      repeat (3) @(posedge clk);
    end
    interrupt = 1'b0;
    apb_rd("count5", 7'h18, 32'h5);

    // Reset in the middle of RUN aborts without capture
    apb_wr("start4", 7'h0C, 32'h31, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    check("mid_rst_xin", xInput, 32'h0);
    check("mid_rst_ctrlin", controlRegisterInput, 32'h0);
    check("mid_rst_pready", {31'b0, pready}, 32'h1);
    interrupt = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_irq", {31'b0, irq}, 32'h0);
    interrupt = 1'b0;
    apb_rd("post_rst_irqreg", 7'h14, 32'h0);
    apb_rd("post_rst_count", 7'h18, 32'h0);
    apb_rd("post_rst_x", 7'h00, 32'h0);
    apb_rd("post_rst_irqen", 7'h1C, 32'h0);
    apb_rd("post_rst_ctrl", 7'h0C, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
